// File: rtl/id_ex_pkg.sv
// Shared types for the ID->EX control pipeline.
//   id_ex_ctrl_t   : packed control bundle carried from decode to execute
//   ID_EX_CTRL_NOP : all-zero bubble presented when the stage is empty
//   pipe_state_e   : occupancy of a 1/2-entry valid/ready register
package id_ex_pkg;

  localparam int ALU_OP_W    = 7;
  localparam int ALU_FUNC3_W = 3;
  localparam int ALU_FUNC7_W = 7;

  typedef struct packed {
    logic                   reg_to_pc;  // operand A: 1 = PC, 0 = register
    logic                   alu_src;    // operand B: 1 = immediate, 0 = register
    logic [ALU_OP_W-1:0]    alu_op;
    logic [ALU_FUNC3_W-1:0] alu_func3;
    logic [ALU_FUNC7_W-1:0] alu_func7;
  } id_ex_ctrl_t;

  localparam int          ID_EX_CTRL_W   = $bits(id_ex_ctrl_t);
  localparam id_ex_ctrl_t ID_EX_CTRL_NOP = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_ONE   = 2'd1,  // main entry held
    ST_TWO   = 2'd2   // main + skid held
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register with an optional skid entry.
//   clk, reset         : clock, asynchronous active-low reset
//   flush              : synchronous squash of every held entry (wins over push)
//   in_valid/in_ready  : upstream handshake, in_data payload
//   out_valid/out_ready: downstream handshake, out_data payload (zero when empty)
// SKID_EN=1 : in_ready depends only on state, so out_ready has no path to in_ready.
// SKID_EN=0 : in_ready = empty | out_ready; the skid state is never entered.
module pipe_skid_reg
  import id_ex_pkg::*;
#(
  parameter type T       = logic [7:0],
  parameter bit  SKID_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  pipe_state_e state_q, state_d;
  T            main_q, skid_q;
  logic        push, pop;
  logic        load_main_in, load_main_skid, clr_main, load_skid, clr_skid;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state logic. Flush empties the register regardless of handshakes.
  // NOTE: every always_comb output gets a default first so no path can hold
  // a previous value and infer a latch.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_TWO;
          else if (pop && !push) state_d = ST_EMPTY;
        end
        ST_TWO:   if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs, decoded from state (and out_ready only without skid).
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    if (SKID_EN) in_ready = (state_q != ST_TWO);
    else         in_ready = (state_q == ST_EMPTY) || out_ready;
  end

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Payload steering: a slot is zeroed whenever it empties, so out_data is
  // the bubble whenever out_valid is low.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    clr_main       = 1'b0;
    load_skid      = 1'b0;
    clr_skid       = 1'b0;
    unique case (state_q)
      ST_EMPTY: load_main_in = push;
      ST_ONE: begin
        if (pop) begin
          load_main_in = push;
          clr_main     = !push;
        end else begin
          load_skid = push;
        end
      end
      ST_TWO: begin
        load_main_skid = pop;
        clr_skid       = pop;
      end
      default: ;
    endcase
  end

  // NOTE: the payload flops are reset on purpose: the empty stage must show an
  // all-zero bundle straight out of reset, not whatever powered up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_data;
      else if (load_main_skid) main_q <= skid_q;
      else if (clr_main)       main_q <= '0;

      if (load_skid)     skid_q <= in_data;
      else if (clr_skid) skid_q <= '0;
    end
  end

  assign out_data = main_q;

endmodule

// File: rtl/id_ex_control_pipe.sv
// ID->EX control-path pipeline register.
//   clk, reset               : clock, asynchronous active-low reset
//   flush                    : squash everything held (branch redirect)
//   in_valid/in_ready        : decode-side handshake
//   *_in                     : reg_to_pc, alu_src, alu_op, alu_func3, alu_func7 from decode
//   out_valid/out_ready      : execute-side handshake
//   *_out                    : held bundle, all zero when out_valid=0
//   stall_count              : saturating count of cycles with out_valid & !out_ready
// The field widths must match id_ex_pkg, since the bundle travels as id_ex_ctrl_t.
module id_ex_control_pipe
  import id_ex_pkg::*;
#(
  parameter int ALU_OP_WIDTH    = 7,
  parameter int ALU_FUNC3_WIDTH = 3,
  parameter int ALU_FUNC7_WIDTH = 7,
  parameter int SKID_EN         = 1,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       reg_to_pc_in,
  input  logic                       alu_src_in,
  input  logic [ALU_OP_WIDTH-1:0]    alu_op_in,
  input  logic [ALU_FUNC3_WIDTH-1:0] alu_func3_in,
  input  logic [ALU_FUNC7_WIDTH-1:0] alu_func7_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       reg_to_pc_out,
  output logic                       alu_src_out,
  output logic [ALU_OP_WIDTH-1:0]    alu_op_out,
  output logic [ALU_FUNC3_WIDTH-1:0] alu_func3_out,
  output logic [ALU_FUNC7_WIDTH-1:0] alu_func7_out,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  if (ALU_OP_WIDTH != ALU_OP_W || ALU_FUNC3_WIDTH != ALU_FUNC3_W ||
      ALU_FUNC7_WIDTH != ALU_FUNC7_W) begin : g_width_check
    $error("id_ex_control_pipe field widths differ from id_ex_ctrl_t");
  end

  id_ex_ctrl_t in_bundle, out_bundle;

  assign in_bundle.reg_to_pc = reg_to_pc_in;
  assign in_bundle.alu_src   = alu_src_in;
  assign in_bundle.alu_op    = alu_op_in;
  assign in_bundle.alu_func3 = alu_func3_in;
  assign in_bundle.alu_func7 = alu_func7_in;

  pipe_skid_reg #(
    .T       (id_ex_ctrl_t),
    .SKID_EN (SKID_EN != 0)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_bundle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bundle)
  );

  assign reg_to_pc_out = out_bundle.reg_to_pc;
  assign alu_src_out   = out_bundle.alu_src;
  assign alu_op_out    = out_bundle.alu_op;
  assign alu_func3_out = out_bundle.alu_func3;
  assign alu_func7_out = out_bundle.alu_func7;

  // Back-pressure counter: a diagnostic that survives flush; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_WIDTH'(1);
    end
  end

endmodule
